// File: rtl/systolic_mm_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mm_controller_if
// Purpose  : Host-side handshake and array-drive bundle of the systolic
//            matrix-multiply controller.
// Revision : 1.0
// ============================================================================
interface systolic_mm_controller_if #(
  parameter int N = 4,
  parameter int K = 4
);
  localparam int T  = K + 2 * N - 2;
  localparam int TW = $clog2(T);
  localparam int KW = ($clog2(K) < 1) ? 1 : $clog2(K);
  localparam int RW = ($clog2(N) < 1) ? 1 : $clog2(N);

  logic            start;
  logic            abort;
  logic            busy;
  logic            array_clear;
  logic [TW-1:0]   step;
  logic [N-1:0]    lane_valid;
  logic [N*KW-1:0] lane_k;
  logic            rd_valid;
  logic [RW-1:0]   rd_row;
  logic            done;

  // master: the controller; slave: the host and array feeders.
  modport master (
    input  start, abort,
    output busy, array_clear, step, lane_valid, lane_k, rd_valid, rd_row, done
  );
  modport slave (
    output start, abort,
    input  busy, array_clear, step, lane_valid, lane_k, rd_valid, rd_row, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_mm_controller.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mm_controller
// Purpose  : Sequences clear, skewed operand feed and row readout of an
//            N x N output-stationary systolic multiply array.
// Revision : 1.0
// ============================================================================
module systolic_mm_controller #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  wire logic                     clock,
  input  wire logic                     nreset,
  systolic_mm_controller_if.master      ctrl
);
  localparam int T  = K + 2 * N - 2;
  localparam int TW = $clog2(T);
  localparam int KW = ($clog2(K) < 1) ? 1 : $clog2(K);
  localparam int RW = ($clog2(N) < 1) ? 1 : $clog2(N);

  localparam logic [TW-1:0] C_T_LAST   = TW'(T - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [RW-1:0]   row_q, row_d;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      row_q   <= row_d;
    end
  end

  // Counters only advance while staying in their own state; any exit zeroes them.
  always_comb begin
    state_d = state_q;
    t_d     = '0;
    row_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (ctrl.start && !ctrl.abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = ctrl.abort ? S_IDLE : S_FEED;
      end
      S_FEED: begin
        if (ctrl.abort) begin
          state_d = S_IDLE;
        end else if (t_q == C_T_LAST) begin
          state_d = S_READ;
        end else begin
          t_d = (t_q == C_T_LAST) ? t_q : t_q + TW'(1);
        end
      end
      S_READ: begin
        if (ctrl.abort) begin
          state_d = S_IDLE;
        end else if (row_q == C_ROW_LAST) begin
          state_d = S_DONE;
        end else begin
          row_d = (row_q == C_ROW_LAST) ? row_q : row_q + RW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ctrl.busy        = (state_q != S_IDLE);
  assign ctrl.array_clear = (state_q == S_CLEAR);
  assign ctrl.step        = (state_q == S_FEED) ? t_q : '0;
  assign ctrl.rd_valid    = (state_q == S_READ);
  assign ctrl.rd_row      = (state_q == S_READ) ? row_q : '0;
  assign ctrl.done        = (state_q == S_DONE);

  // Lane i is skewed by i cycles so operands meet diagonally inside the array.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic w_in_window;
    assign w_in_window = (state_q == S_FEED) &&
                         (int'(t_q) >= i) && (int'(t_q) <= i + K - 1);
    assign ctrl.lane_valid[i]         = w_in_window;
    assign ctrl.lane_k[i*KW +: KW]    = w_in_window ? KW'(int'(t_q) - i) : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_mm_controller
// Purpose  : Scoreboard bench: controller drives a behavioural 4x4 systolic
//            array; every busy cycle is matched against a pre-pushed record.
// Revision : 1.0
// ============================================================================
module tb_systolic_mm_controller;
  logic clock  = 1'b0;
  logic nreset = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  systolic_mm_controller_if #(.N(4), .K(4)) bus ();

  systolic_mm_controller #(.N(4), .K(4)) dut (
    .clock  (clock),
    .nreset (nreset),
    .ctrl   (bus)
  );

  typedef struct packed {
    int          cyc;
    logic        clr;
    logic [3:0]  step;
    logic [3:0]  lv;
    logic [7:0]  lk;
    logic        rv;
    logic [1:0]  row;
    logic        dn;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];

  // Hand-derived lane patterns for N=4, K=4, indexed by feed step t.
  logic [3:0] lv_tab [0:9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                               4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic [7:0] lk_tab [0:9] = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C,
                               8'hB0, 8'hC0, 8'h00, 8'h00, 8'h00};

  // Behavioural output-stationary array; A = B = I + ones.
  int A [4][4];
  int B [4][4];
  int acc [4][4];
  int a_r [4][4];
  int b_r [4][4];

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j]   = (i == j) ? 2 : 1;
        B[i][j]   = (i == j) ? 2 : 1;
        acc[i][j] = 0;
        a_r[i][j] = 0;
        b_r[i][j] = 0;
      end
  end

  always @(posedge clock) begin
    int ain, bin;
    logic [1:0] k;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (bus.array_clear) begin
          acc[i][j] <= 0;
          a_r[i][j] <= 0;
          b_r[i][j] <= 0;
        end else begin
          if (j == 0) begin
            k   = bus.lane_k[2*i +: 2];
            ain = bus.lane_valid[i] ? A[i][k] : 0;
          end else begin
            ain = a_r[i][j-1];
          end
          if (i == 0) begin
            k   = bus.lane_k[2*j +: 2];
            bin = bus.lane_valid[j] ? B[k][j] : 0;
          end else begin
            bin = b_r[i-1][j];
          end
          a_r[i][j] <= ain;
          b_r[i][j] <= bin;
          acc[i][j] <= acc[i][j] + ain * bin;
        end
      end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // (I+J)^2 = I + 6J for 4x4: 7 on the diagonal, 6 elsewhere.
  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) v[16*c +: 16] = (c == r) ? 16'd7 : 16'd6;
    return v;
  endfunction

  task automatic push_run(input int c0, input int last);
    exp_t e;
    for (int off = 1; off <= last; off++) begin
      e     = '0;
      e.cyc = c0 + off;
      if (off == 1) begin
        e.clr = 1'b1;
      end else if (off <= 11) begin
        e.step = 4'(off - 2);
        e.lv   = lv_tab[off-2];
        e.lk   = lk_tab[off-2];
      end else if (off <= 15) begin
        e.rv   = 1'b1;
        e.row  = 2'(off - 12);
        e.data = exp_row(off - 12);
      end else begin
        e.dn   = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic [63:0] rdata;
    if (nreset && bus.busy) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_busy at cycle %0d: actual=busy required=idle", cyc);
      end else begin
        e = q.pop_front();
        chk("cycle", 64'(cyc), 64'(e.cyc));
        chk("outputs",
            64'({bus.array_clear, bus.step, bus.lane_valid, bus.lane_k,
                 bus.rd_valid, bus.rd_row, bus.done}),
            64'({e.clr, e.step, e.lv, e.lk, e.rv, e.row, e.dn}));
        if (e.rv) begin
          for (int c = 0; c < 4; c++) rdata[16*c +: 16] = 16'(acc[bus.rd_row][c]);
          chk("row_data", rdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic drain();
    int b = 0;
    while (q.size() != 0 && b < 100) begin
      tick();
      b++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'({bus.busy, bus.array_clear, bus.step, bus.lane_valid, bus.lane_k,
                   bus.rd_valid, bus.rd_row, bus.done}), 64'(0));
  endtask

  initial begin
    int c0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #3;
    chk_all_zero("reset_outputs");
    tick();
    tick();
    nreset = 1'b1;
    tick();

    // abort wins over start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clock);
    chk("abort_wins_idle", 64'(bus.busy), 64'(0));
    tick();

    // single run; starts while busy and during DONE are ignored
    c0 = cyc;
    push_run(c0, 16);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_cyc(c0 + 5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_cyc(c0 + 16);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clock);
    chk("idle_after_done", 64'(bus.busy), 64'(0));
    tick();
    @(negedge clock);
    chk("done_start_ignored", 64'(bus.busy), 64'(0));
    drain();
    tick();

    // start held high: three back-to-back runs, one IDLE cycle between
    c0 = cyc;
    push_run(c0, 16);
    push_run(c0 + 17, 16);
    push_run(c0 + 34, 16);
    bus.start = 1'b1;
    wait_cyc(c0 + 35);
    bus.start = 1'b0;
    drain();
    tick();
    @(negedge clock);
    chk("idle_after_held", 64'(bus.busy), 64'(0));
    tick();

    // abort at FEED t=5
    c0 = cyc;
    push_run(c0, 7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_cyc(c0 + 7);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clock);
    chk_all_zero("after_abort");
    drain();
    tick();

    c0 = cyc;
    push_run(c0, 16);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain();
    tick();
    tick();

    // asynchronous reset during READ row 2
    c0 = cyc;
    push_run(c0, 14);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_cyc(c0 + 14);
    @(negedge clock);
    #2;
    nreset = 1'b0;
    #1;
    chk_all_zero("async_reset_outputs");
    tick();
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk_all_zero("idle_after_reset");
    end
    drain();
    tick();

    c0 = cyc;
    push_run(c0, 16);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/systolic_mm_controller.md
SYSTOLIC_MM_CONTROLLER -- requirements
Module: systolic_mm_controller

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N x N accumulator cells), N >= 2.
REQ-002 Parameter K, default 4: inner (reduction) dimension of the product, K >= 1.
REQ-003 Derived constants: T = K + 2N - 2 (feed cycles); TW = clog2(T); KW = clog2(K) (min 1); RW = clog2(N) (min 1).
REQ-004 clock  input  1  single clock, all state updates on rising edge.
REQ-005 nreset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one matrix multiply; sampled only in IDLE.
REQ-007 abort  input  1  cancel current operation; sampled in every non-IDLE state.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 array_clear  output  1  one-cycle pulse clearing all cell accumulators and pipeline registers.
REQ-010 step  output  TW  feed-cycle index t, 0..T-1 during FEED, 0 otherwise.
REQ-011 lane_valid  output  N  bit i: row lane i and column lane i receive a real operand this cycle.
REQ-012 lane_k  output  N*KW  packed, slice i = reduction index k for lane i.
REQ-013 rd_valid  output  1  result row readout strobe.
REQ-014 rd_row  output  RW  row index of the accumulator row being read.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, FEED, READ, DONE, all transitions registered.
REQ-017 IDLE: start=1 and abort=0 -> CLEAR; otherwise stay IDLE.
REQ-018 CLEAR lasts exactly 1 cycle with array_clear=1, then -> FEED with t=0.
REQ-019 FEED lasts exactly T cycles, t incrementing by 1 per cycle from 0 to T-1, then -> READ.
REQ-020 In FEED, lane_valid[i] SHALL be 1 iff i <= t <= i+K-1, and lane_k slice i SHALL equal t-i when valid, 0 when invalid.
REQ-021 Feeders SHALL drive zero operands on lanes with lane_valid=0, so invalid lanes contribute nothing to the accumulators.
REQ-022 READ lasts exactly N cycles with rd_valid=1 and rd_row = 0,1,..,N-1 in order, then -> DONE.
REQ-023 DONE lasts 1 cycle with done=1, then -> IDLE; a start in the DONE cycle is ignored.
REQ-024 Start-to-done latency SHALL be 1 + T + N + 1 cycles after the edge sampling start (16 for N=4, K=4).
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 abort=1 in CLEAR, FEED, READ or DONE SHALL force IDLE on the next edge: step=0, lane_valid=0, rd_valid=0, done not pulsed.
REQ-027 abort=1 together with start=1 in IDLE SHALL keep IDLE (abort wins).
REQ-028 Counters SHALL never wrap: t saturates at T-1 and the row counter at N-1 until the state changes.
REQ-029 Outputs SHALL be registered or decoded only from state/counters, with no combinational path from start or abort.

Reset
REQ-030 nreset=0 SHALL immediately force IDLE with t=0 and row=0, and busy, array_clear, lane_valid, lane_k, step, rd_valid, rd_row and done all 0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no done pulse; after release the block waits in IDLE for a new start.

Verification
REQ-032 N=4, K=4, start pulse at cycle 0 -> array_clear at cycle 1; FEED cycles 2-11 (step 0..9); rd_row 0..3 at cycles 12-15; done at cycle 16 only.
REQ-033 During the same FEED, check lane_valid: t=0 -> 0001, t=3 -> 1111, t=5 -> 1100, t=9 -> 0000; lane_k slice 2 at t=4 -> 2.
REQ-034 With the controller driving a 4x4 cell array with A=B=identity-plus-ones test matrices, the read rows SHALL match a reference matrix product exactly; repeating the run back-to-back SHALL give the same result (array_clear effective).
REQ-035 abort at FEED t=5 -> IDLE next cycle, busy=0, no done; a new start then completes normally in 16 cycles.
REQ-036 start held high continuously -> operations run back-to-back: a new CLEAR begins on the cycle after each DONE, and start during busy causes no glitch.
REQ-037 nreset pulsed low during READ (rd_row=2) -> all outputs 0 asynchronously, IDLE after release, no done pulse.
